// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception unit: sequencer states, PC-source
// mux encodings, handler vector base address and exception cause codes.
package exception_unit_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SAVE      = 3'd1,
        MEM_REQ   = 3'd2,
        MEM_WAIT  = 3'd3,
        LOAD      = 3'd4,
        ERET_LOAD = 3'd5
    } ExcState;

    localparam logic [2:0] PC_SRC_SEQUENTIAL = 3'b000;
    localparam logic [2:0] PC_SRC_ALU        = 3'b001;
    localparam logic [2:0] PC_SRC_BRANCH     = 3'b010;
    localparam logic [2:0] PC_SRC_VECTOR     = 3'b011;
    localparam logic [2:0] PC_SRC_EPC        = 3'b100;

    localparam logic [31:0] VECTOR_BASE = 32'd253;

    localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
    localparam logic [1:0] CAUSE_DIV0     = 2'd2;

    // Byte address of the memory word that holds the handler vector for a cause
    function automatic logic [31:0] vectorAddr(input logic [1:0] causeCode);
        return VECTOR_BASE + {30'b0, causeCode};
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder for the three exception request lines.
// req[0] = nonexistent opcode, req[1] = overflow, req[2] = divide by zero.
module exc_priority_enc
    import exception_unit_pkg::*;
(
    input  logic [2:0] req,
    output logic       valid,
    output logic [1:0] cause
);

    // Lowest-numbered request wins; cause is meaningless when valid is low
    always_comb begin
        valid = |req;
        cause = CAUSE_OPCODE;
        if (req[0]) begin
            cause = CAUSE_OPCODE;
        end else if (req[1]) begin
            cause = CAUSE_OVERFLOW;
        end else if (req[2]) begin
            cause = CAUSE_DIV0;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer: saves the faulting PC, fetches the handler vector from
// memory and requests a PC load; also services return-from-exception.
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        eret,
    input  logic [31:0] pc_value,
    input  logic [31:0] mem_data,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_sel,
    output logic [31:0] EPC_out,
    output logic [31:0] vector_out,
    output logic [2:0]  PC_src_req,
    output logic        pc_write_req,
    output logic        busy,
    output logic [1:0]  cause
);

    ExcState    state;
    logic [2:0] waitCount;
    logic       excValid;
    logic [1:0] excCause;
    logic       unusedMemHigh;

    // Only the low byte of the vector word carries the handler address
    assign unusedMemHigh = ^mem_data[31:8];

    exc_priority_enc priorityEnc (
        .req   ({exc_div0, exc_overflow, exc_opcode}),
        .valid (excValid),
        .cause (excCause)
    );

    // Sequencer with registered outputs: every output is updated on the edge
    // that enters the state it belongs to, so requests arriving while busy
    // are simply never looked at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            waitCount    <= 3'd0;
            EPC_out      <= 32'd0;
            vector_out   <= 32'd0;
            exc_mem_addr <= 32'd0;
            exc_mem_sel  <= 1'b0;
            cause        <= 2'd0;
            PC_src_req   <= PC_SRC_SEQUENTIAL;
            pc_write_req <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (excValid) begin
                        state        <= SAVE;
                        cause        <= excCause;
                        EPC_out      <= pc_value - 32'd4;
                        exc_mem_addr <= vectorAddr(excCause);
                        busy         <= 1'b1;
                    end else if (eret) begin
                        state        <= ERET_LOAD;
                        PC_src_req   <= PC_SRC_EPC;
                        pc_write_req <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                SAVE: begin
                    state       <= MEM_REQ;
                    exc_mem_sel <= 1'b1;
                end
                MEM_REQ: begin
                    state     <= MEM_WAIT;
                    waitCount <= 3'(MEM_LATENCY);
                end
                MEM_WAIT: begin
                    if (waitCount <= 3'd1) begin
                        state        <= LOAD;
                        waitCount    <= 3'd0;
                        vector_out   <= {24'b0, mem_data[7:0]};
                        exc_mem_sel  <= 1'b0;
                        exc_mem_addr <= 32'd0;
                        PC_src_req   <= PC_SRC_VECTOR;
                        pc_write_req <= 1'b1;
                    end else begin
                        waitCount <= waitCount - 3'd1;
                    end
                end
                LOAD, ERET_LOAD: begin
                    state        <= IDLE;
                    PC_src_req   <= PC_SRC_SEQUENTIAL;
                    pc_write_req <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    waitCount    <= 3'd0;
                    exc_mem_sel  <= 1'b0;
                    exc_mem_addr <= 32'd0;
                    PC_src_req   <= PC_SRC_SEQUENTIAL;
                    pc_write_req <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: two instances (memory latency 1 and 4) share all
// inputs and are compared every cycle against a cycle-count reference model.
module tb_exception_unit;

    logic        clk;
    logic        reset;
    logic        excOpcode;
    logic        excOverflow;
    logic        excDiv0;
    logic        eretReq;
    logic [31:0] pcValue;
    logic [31:0] memData;

    logic [31:0] memAddr   [2];
    logic        memSel    [2];
    logic [31:0] epcOut    [2];
    logic [31:0] vectorOut [2];
    logic [2:0]  pcSrc     [2];
    logic        pcWrite   [2];
    logic        busyOut   [2];
    logic [1:0]  causeOut  [2];

    int compareCount = 0;
    int errCount     = 0;

    // Reference model state: cycles since acceptance (0 = idle)
    int          lat       [2] = '{1, 4};
    int          tSince    [2];
    bit          modeEret  [2];
    logic [1:0]  mCause    [2];
    logic [31:0] mEpc      [2];
    logic [31:0] mVec      [2];

    exception_unit #(.MEM_LATENCY(1)) dutLat1 (
        .clk          (clk),
        .reset        (reset),
        .exc_opcode   (excOpcode),
        .exc_overflow (excOverflow),
        .exc_div0     (excDiv0),
        .eret         (eretReq),
        .pc_value     (pcValue),
        .mem_data     (memData),
        .exc_mem_addr (memAddr[0]),
        .exc_mem_sel  (memSel[0]),
        .EPC_out      (epcOut[0]),
        .vector_out   (vectorOut[0]),
        .PC_src_req   (pcSrc[0]),
        .pc_write_req (pcWrite[0]),
        .busy         (busyOut[0]),
        .cause        (causeOut[0])
    );

    exception_unit #(.MEM_LATENCY(4)) dutLat4 (
        .clk          (clk),
        .reset        (reset),
        .exc_opcode   (excOpcode),
        .exc_overflow (excOverflow),
        .exc_div0     (excDiv0),
        .eret         (eretReq),
        .pc_value     (pcValue),
        .mem_data     (memData),
        .exc_mem_addr (memAddr[1]),
        .exc_mem_sel  (memSel[1]),
        .EPC_out      (epcOut[1]),
        .vector_out   (vectorOut[1]),
        .PC_src_req   (pcSrc[1]),
        .pc_write_req (pcWrite[1]),
        .busy         (busyOut[1]),
        .cause        (causeOut[1])
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit opc, input bit ovf, input bit dz, input bit er,
                                 input logic [31:0] pc, input logic [31:0] md);
        excOpcode   = opc;
        excOverflow = ovf;
        excDiv0     = dz;
        eretReq     = er;
        pcValue     = pc;
        memData     = md;
    endtask

    task automatic resetModels();
        for (int i = 0; i < 2; i++) begin
            tSince[i]   = 0;
            modeEret[i] = 1'b0;
            mCause[i]   = 2'd0;
            mEpc[i]     = 32'd0;
            mVec[i]     = 32'd0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic updateModels();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                tSince[i] = 0;
            end else if (tSince[i] == 0) begin
                if (excOpcode || excOverflow || excDiv0) begin
                    tSince[i]   = 1;
                    modeEret[i] = 1'b0;
                    mCause[i]   = excOpcode ? 2'd0 : (excOverflow ? 2'd1 : 2'd2);
                    mEpc[i]     = pcValue - 32'd4;
                end else if (eretReq) begin
                    tSince[i]   = 1;
                    modeEret[i] = 1'b1;
                end
            end else if (modeEret[i] || tSince[i] == 3 + lat[i]) begin
                tSince[i] = 0;
            end else begin
                tSince[i]++;
                if (tSince[i] == 3 + lat[i]) mVec[i] = {24'b0, memData[7:0]};
            end
        end
    endtask

    task automatic checkModels();
        for (int i = 0; i < 2; i++) begin
            int  t;
            bit  expWrite;
            bit  expSel;
            logic [2:0] expSrc;
            t        = tSince[i];
            expWrite = (t != 0) && (modeEret[i] ? (t == 1) : (t == 3 + lat[i]));
            expSel   = (t != 0) && !modeEret[i] && t >= 2 && t <= 2 + lat[i];
            expSrc   = !expWrite ? 3'b000 : (modeEret[i] ? 3'b100 : 3'b011);
            checkOutput($sformatf("L%0d busy", lat[i]), 32'(busyOut[i]), 32'(t != 0));
            checkOutput($sformatf("L%0d pc_write_req", lat[i]), 32'(pcWrite[i]), 32'(expWrite));
            checkOutput($sformatf("L%0d PC_src_req", lat[i]), 32'(pcSrc[i]), 32'(expSrc));
            checkOutput($sformatf("L%0d exc_mem_sel", lat[i]), 32'(memSel[i]), 32'(expSel));
            checkOutput($sformatf("L%0d cause", lat[i]), 32'(causeOut[i]), 32'(mCause[i]));
            checkOutput($sformatf("L%0d EPC_out", lat[i]), epcOut[i], mEpc[i]);
            checkOutput($sformatf("L%0d vector_out", lat[i]), vectorOut[i], mVec[i]);
            if (t != 0 && !modeEret[i] && t <= 2 + lat[i])
                checkOutput($sformatf("L%0d exc_mem_addr", lat[i]), memAddr[i], 32'd253 + 32'(mCause[i]));
        end
    endtask

    // One clock: update model at the edge, check just after, return at negedge
    task automatic stepCycle();
        @(posedge clk);
        updateModels();
        #1;
        checkModels();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear at once
    task automatic pulseReset();
        #2;
        reset = 1'b1;
        #1;
        resetModels();
        checkModels();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("L%0d reset exc_mem_addr", lat[i]), memAddr[i], 32'd0);
        end
        @(negedge clk);
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        $display("[TB] starting exception_unit bench");
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
        resetModels();
        #1;
        checkModels();
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("L%0d reset exc_mem_addr", lat[i]), memAddr[i], 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Overflow with pc 0x40 and vector byte 0x80
        applyStimulus(0, 1, 0, 0, 32'h0000_0040, 32'h0000_1280);
        stepCycle();
        checkOutput("dir overflow cause", 32'(causeOut[0]), 32'd1);
        checkOutput("dir overflow EPC", epcOut[0], 32'h0000_003C);
        checkOutput("dir overflow addr", memAddr[0], 32'd254);
        applyStimulus(0, 0, 0, 0, 32'h0000_0044, 32'h0000_1280);
        for (int c = 0; c < 2; c++) stepCycle();
        // Divide-by-zero arrives while both instances are mid-sequence
        applyStimulus(0, 0, 1, 0, 32'h0000_0100, 32'h0000_1280);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 32'h0000_0100, 32'h0000_1280);
        for (int c = 0; c < 6; c++) stepCycle();
        checkOutput("dir overflow vector", vectorOut[0], 32'h0000_0080);
        checkOutput("dir div0 ignored cause", 32'(causeOut[1]), 32'd1);

        // Return from exception with EPC = 0x3C
        applyStimulus(0, 0, 0, 1, 32'h0000_0200, 32'h0);
        stepCycle();
        checkOutput("dir eret src", 32'(pcSrc[0]), 32'd4);
        checkOutput("dir eret write", 32'(pcWrite[0]), 32'd1);
        applyStimulus(0, 0, 0, 0, 32'h0000_0200, 32'h0);
        stepCycle();
        checkOutput("dir eret done busy", 32'(busyOut[0]), 32'd0);

        // All requests together: opcode wins, eret is not taken
        applyStimulus(1, 1, 1, 1, 32'h0000_1000, 32'h0000_00AA);
        stepCycle();
        checkOutput("dir all cause", 32'(causeOut[0]), 32'd0);
        checkOutput("dir all addr", memAddr[0], 32'd253);
        checkOutput("dir all src", 32'(pcSrc[0]), 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h0000_1000, 32'h0000_00AA);
        for (int c = 0; c < 8; c++) stepCycle();

        // Reset while the latency-4 instance sits in its memory wait
        applyStimulus(0, 0, 1, 0, 32'h0000_2000, 32'h0000_0055);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 32'h0000_2000, 32'h0000_0055);
        for (int c = 0; c < 3; c++) stepCycle();
        pulseReset();
        applyStimulus(0, 1, 0, 0, 32'h0000_0000, 32'h0000_0011);
        stepCycle();
        checkOutput("dir pc0 EPC", epcOut[0], 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0011);
        for (int c = 0; c < 8; c++) stepCycle();

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                          $urandom(), $urandom());
            if ($urandom_range(0, 199) == 0) pulseReset();
            else stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 1, meaning the number of wait cycles between driving exc_mem_addr and sampling mem_data (range 1..4).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port exc_opcode, input, 1, nonexistent-opcode exception request, sampled at clk edge.
REQ-005 The block SHALL have port exc_overflow, input, 1, ALU overflow exception request.
REQ-006 The block SHALL have port exc_div0, input, 1, divide-by-zero exception request.
REQ-007 The block SHALL have port eret, input, 1, return-from-exception request.
REQ-008 The block SHALL have port pc_value, input, 32, current PC register contents.
REQ-009 The block SHALL have port mem_data, input, 32, memory read data.
REQ-010 The block SHALL have port exc_mem_addr, output, 32, memory byte address of the handler vector.
REQ-011 The block SHALL have port exc_mem_sel, output, 1, high when exc_mem_addr owns the memory address mux.
REQ-012 The block SHALL have port EPC_out, output, 32, saved exception PC, feeds PC-source mux input 3'b100.
REQ-013 The block SHALL have port vector_out, output, 32, handler address, feeds PC-source mux input 3'b011.
REQ-014 The block SHALL have ports PC_src_req (output, 3, PC-source select requested) and pc_write_req (output, 1, one-cycle PC load strobe).
REQ-015 The block SHALL have ports busy (output, 1, sequence in progress) and cause (output, 2, code of the last accepted exception).

Function
REQ-016 States SHALL be IDLE, SAVE, MEM_REQ, MEM_WAIT, LOAD, ERET_LOAD.
REQ-017 In IDLE, any exception input high SHALL move to SAVE; else eret high SHALL move to ERET_LOAD; else stay.
REQ-018 Priority SHALL be exc_opcode (cause 0) > exc_overflow (cause 1) > exc_div0 (cause 2); exception beats eret on the same edge.
REQ-019 On the IDLE->SAVE edge, cause SHALL latch the winning code and EPC SHALL latch pc_value - 4 (modulo 2^32; pc_value 0 gives 32'hFFFF_FFFC).
REQ-020 SAVE SHALL last one cycle then go to MEM_REQ; exc_mem_addr SHALL be 253 + cause (253/254/255) from SAVE through MEM_WAIT.
REQ-021 exc_mem_sel SHALL be high in MEM_REQ and MEM_WAIT only.
REQ-022 MEM_WAIT SHALL last exactly MEM_LATENCY cycles (internal down-counter), then go to LOAD.
REQ-023 On MEM_WAIT->LOAD edge vector_out SHALL latch {24'b0, mem_data[7:0]}.
REQ-024 In LOAD: PC_src_req = 3'b011, pc_write_req = 1 for exactly one cycle, then IDLE.
REQ-025 In ERET_LOAD: PC_src_req = 3'b100, pc_write_req = 1 for exactly one cycle, then IDLE; EPC_out unchanged.
REQ-026 Outside LOAD/ERET_LOAD, PC_src_req SHALL be 3'b000 and pc_write_req 0.
REQ-027 busy SHALL be high in every state except IDLE; exception and eret inputs SHALL be ignored while busy (not queued).
REQ-028 Exception-to-PC-load latency SHALL be 3 + MEM_LATENCY cycles from the accepting edge; eret latency 1 cycle.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE and set EPC_out, vector_out, exc_mem_addr, cause, PC_src_req, pc_write_req, exc_mem_sel, busy and wait counter to 0.
REQ-030 Reset mid-sequence SHALL abort it with no pc_write_req pulse; first acceptance is on the first clk edge after deassertion.

Structure
REQ-031 A shared package SHALL hold PC_src encodings (3'b000..3'b100), vector base 253, cause codes 0..2 and the state enum.
REQ-032 The block SHALL contain one sub-module, exc_priority_enc (3 request bits -> valid + 2-bit cause, combinational).

Verification
REQ-033 exc_overflow pulse, pc_value=32'h0000_0040, mem_data[7:0]=8'h80, MEM_LATENCY=1 -> cause=1, EPC_out=32'h3C, exc_mem_addr=254, 4 cycles later PC_src_req=3'b011, pc_write_req one cycle, vector_out=32'h80.
REQ-034 exc_opcode, exc_overflow, exc_div0 and eret all high same edge -> cause=0, exc_mem_addr=253, no ERET_LOAD.
REQ-035 eret in IDLE with EPC_out=32'h3C -> next cycle PC_src_req=3'b100, pc_write_req=1, then IDLE.
REQ-036 exc_div0 asserted during MEM_WAIT -> ignored, cause unchanged, single pc_write_req.
REQ-037 Reset asserted in MEM_WAIT -> outputs 0 asynchronously, no pc_write_req; pc_value=0 exception afterwards -> EPC_out=32'hFFFF_FFFC.
REQ-038 MEM_LATENCY=4 -> exc_mem_sel high 5 cycles, pc_write_req 7 cycles after accepting edge.
